// File: rtl/polyeta_pkg.sv
// Shared constants and controller state type for the polyeta unpack datapath.
package polyeta_pkg;
  localparam int N               = 256;
  localparam int ETA             = 4;
  localparam int COEFFS_PER_WORD = 8;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EMIT,
    FIN
  } ctrlState_e;
endpackage

// File: rtl/polyeta_coeff_decode.sv
// Combinational nibble decoder: coeff = ETA - t as 32-bit signed, plus a flag for t > 2*ETA.
module polyeta_coeff_decode
  import polyeta_pkg::*;
#(
  parameter int ETA = polyeta_pkg::ETA
) (
  input  logic        [3:0]  nibble_i,
  output logic signed [31:0] coeff_o,
  output logic               rangeErr_o
);

  localparam logic signed [31:0] ETA_S   = 32'(ETA);
  localparam logic        [31:0] LIMIT_U = 32'(2 * ETA);

  logic [31:0] nibbleWide;

  assign nibbleWide = {28'd0, nibble_i};
  assign coeff_o    = ETA_S - $signed(nibbleWide);
  assign rangeErr_o = (nibbleWide > LIMIT_U);

endmodule

// File: rtl/polyeta_unpack_ctrl.sv
// Unpacks 32-bit words of eight 4-bit nibbles into signed coefficients, 256 per polynomial.
// Optional sticky range check on t > 2*ETA is built only when POLYETA_RANGE_CHECK_EN is defined.
module polyeta_unpack_ctrl
  import polyeta_pkg::*;
#(
  parameter int ETA       = polyeta_pkg::ETA,
  parameter int MAX_POLYS = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic        [3:0]  num_polys,
  input  logic        [31:0] in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [31:0] out_coeff,
  output logic        [7:0]  out_addr,
  output logic        [2:0]  out_poly,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [3:0] MAX_P     = 4'(MAX_POLYS);
  localparam logic [2:0] LAST_NIB  = 3'(COEFFS_PER_WORD - 1);
  localparam logic [7:0] LAST_ADDR = 8'(N - 1);

  ctrlState_e state_q, state_d;
  logic [3:0]  numPolys_q, numPolys_d;
  logic [31:0] word_q, word_d;
  logic [2:0]  nibIdx_q, nibIdx_d;
  logic [7:0]  addr_q, addr_d;
  logic [2:0]  poly_q, poly_d;

  logic               acceptStart;
  logic               lastPoly;
  logic [3:0]         curNibble;
  logic signed [31:0] decCoeff;
  logic               rangeErr;

  assign acceptStart = (state_q == IDLE) && start;
  assign lastPoly    = ({1'b0, poly_q} == (numPolys_q - 4'd1));
  assign curNibble   = word_q[{nibIdx_q, 2'b00} +: 4];

  polyeta_coeff_decode #(
    .ETA(ETA)
  ) uDecode (
    .nibble_i  (curNibble),
    .coeff_o   (decCoeff),
    .rangeErr_o(rangeErr)
  );

  always_comb begin
    state_d    = state_q;
    numPolys_d = numPolys_q;
    word_d     = word_q;
    nibIdx_d   = nibIdx_q;
    addr_d     = addr_q;
    poly_d     = poly_q;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (acceptStart) begin
          numPolys_d = (num_polys > MAX_P) ? MAX_P : num_polys;
          nibIdx_d   = '0;
          addr_d     = '0;
          poly_d     = '0;
          state_d    = (num_polys == 4'd0) ? FIN : FETCH;
        end
      end
      FETCH: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          word_d   = in_word;
          nibIdx_d = '0;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) begin
          nibIdx_d = nibIdx_q + 3'd1;
          addr_d   = addr_q + 8'd1;
          // Word exhausted: fetch the next one unless this closed the final polynomial.
          if (nibIdx_q == LAST_NIB) begin
            state_d = FETCH;
            if (addr_q == LAST_ADDR) begin
              poly_d = poly_q + 3'd1;
              if (lastPoly) begin
                state_d = FIN;
              end
            end
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      numPolys_q <= '0;
      word_q     <= '0;
      nibIdx_q   <= '0;
      addr_q     <= '0;
      poly_q     <= '0;
    end else begin
      state_q    <= state_d;
      numPolys_q <= numPolys_d;
      word_q     <= word_d;
      nibIdx_q   <= nibIdx_d;
      addr_q     <= addr_d;
      poly_q     <= poly_d;
    end
  end

  assign out_coeff = out_valid ? decCoeff : '0;
  assign out_addr  = addr_q;
  assign out_poly  = poly_q;

`ifdef POLYETA_RANGE_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (acceptStart) begin
      err_d = 1'b0;
    end else if (out_valid && out_ready && rangeErr) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  // Range flag is discarded when checking is compiled out.
  logic unusedRange;
  assign unusedRange = rangeErr;
  assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_polyeta_unpack_ctrl.sv
// Randomized self-checking bench for polyeta_unpack_ctrl against a transfer-index model.
// Expects err to track t > 2*ETA when POLYETA_RANGE_CHECK_EN is defined, else to stay 0.
module tb_polyeta_unpack_ctrl;

  localparam int ETA       = 4;
  localparam int MAX_POLYS = 8;
  localparam int BUDGET    = 20000;
`ifdef POLYETA_RANGE_CHECK_EN
  localparam bit RANGE_EN = 1'b1;
`else
  localparam bit RANGE_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic        [3:0]  num_polys;
  logic        [31:0] in_word;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] out_coeff;
  logic        [7:0]  out_addr;
  logic        [2:0]  out_poly;
  logic               out_valid;
  logic               out_ready;
  logic               busy;
  logic               done;
  logic               err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  polyeta_unpack_ctrl #(
    .ETA      (ETA),
    .MAX_POLYS(MAX_POLYS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .num_polys(num_polys),
    .in_word  (in_word),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_coeff(out_coeff),
    .out_addr (out_addr),
    .out_poly (out_poly),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Pulses start for one cycle; returns at posedge+1 with the request sampled.
  task automatic start_job(input logic [3:0] n);
    start     = 1'b1;
    num_polys = n;
    @(posedge clk); #1;
    start     = 1'b0;
    num_polys = 4'($urandom);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL err_cleared_by_start got=%b exp=0", err);
    end
    if (n != 4'd0) begin
      checks++;
      if (busy !== 1'b1) begin
        failures++;
        $display("[TB] FAIL busy_after_start got=%b exp=1", busy);
      end
    end
  endtask

  // Runs one job and checks every coefficient transfer against the nibble stream model.
  task automatic run_job(input logic [3:0] n, input bit useFirst, input logic [31:0] firstWord,
                         input int validPct, input int readyPct, input bit toggleReady,
                         input bit pokeStart, input int abortAt, input bit checkRate);
    int nSat, total, totalWords, sent, got, cycles, lastXfer, expCoeff;
    bit doneSeen, stallPrev, inXferPrev, expErr;
    logic [31:0] words[$];
    logic [31:0] w;
    logic [3:0]  t;
    logic signed [31:0] prevCoeff;
    logic [7:0] prevAddr;
    logic [2:0] prevPoly;

    nSat       = (int'(n) > MAX_POLYS) ? MAX_POLYS : int'(n);
    total      = nSat * 256;
    totalWords = nSat * 32;
    for (int i = 0; i < totalWords; i++) begin
      words.push_back((i == 0 && useFirst) ? firstWord : $urandom);
    end
    sent = 0; got = 0; lastXfer = -1; doneSeen = 0; stallPrev = 0; inXferPrev = 0; expErr = 0;
    prevCoeff = '0; prevAddr = '0; prevPoly = '0;

    start_job(n);

    for (cycles = 0; cycles < BUDGET; cycles++) begin
      start = 1'b0;
      if (done === 1'b1) begin
        doneSeen = 1;
        checks++;
        if (got != total || cycles != lastXfer + 1) begin
          failures++;
          $display("[TB] FAIL done_timing got=%0d transfers at cycle %0d exp=%0d transfers at cycle %0d",
                   got, cycles, total, lastXfer + 1);
        end
        checks++;
        if (busy !== 1'b0 || err !== expErr) begin
          failures++;
          $display("[TB] FAIL fin_flags busy=%b err=%b exp busy=0 err=%b", busy, err, expErr);
        end
        if (checkRate) begin
          checks++;
          if (cycles != totalWords * 9) begin
            failures++;
            $display("[TB] FAIL throughput cycles=%0d exp=%0d", cycles, totalWords * 9);
          end
        end
        break;
      end
      checks++;
      if (in_ready === 1'b1 && out_valid === 1'b1) begin
        failures++;
        $display("[TB] FAIL in_ready_in_emit got in_ready=1 out_valid=1 exp not both");
      end
      if (inXferPrev) begin
        checks++;
        if (out_valid !== 1'b1) begin
          failures++;
          $display("[TB] FAIL first_valid got=%b exp=1", out_valid);
        end
      end
      if (stallPrev) begin
        checks++;
        if (out_valid !== 1'b1 || out_coeff !== prevCoeff || out_addr !== prevAddr || out_poly !== prevPoly) begin
          failures++;
          $display("[TB] FAIL stall_hold got v=%b c=%0d a=%0d p=%0d exp v=1 c=%0d a=%0d p=%0d",
                   out_valid, out_coeff, out_addr, out_poly, prevCoeff, prevAddr, prevPoly);
        end
      end

      in_word  = (sent < totalWords) ? words[sent] : $urandom;
      in_valid = (sent < totalWords) && (int'($urandom_range(99, 0)) < validPct);
      out_ready = toggleReady ? (cycles % 2 == 0) : (int'($urandom_range(99, 0)) < readyPct);
      if (pokeStart) begin
        start     = ($urandom_range(3, 0) == 0);
        num_polys = 4'($urandom);
      end
      inXferPrev = (in_valid && in_ready === 1'b1);
      if (inXferPrev) sent++;

      stallPrev = 0;
      if (out_valid === 1'b1) begin
        if (out_ready) begin
          w = words[got / 8];
          t = w[(got % 8) * 4 +: 4];
          expCoeff = ETA - int'(t);
          if (RANGE_EN && int'(t) > 2 * ETA) expErr = 1;
          checks++;
          if (got >= total || out_coeff !== 32'(expCoeff) || out_addr !== 8'(got % 256) ||
              out_poly !== 3'(got / 256)) begin
            failures++;
            $display("[TB] FAIL coeff_xfer k=%0d got c=%0d a=%0d p=%0d exp c=%0d a=%0d p=%0d",
                     got, out_coeff, out_addr, out_poly, expCoeff, got % 256, got / 256);
          end
          got++;
          lastXfer = cycles;
          if (got == abortAt) return;
        end else begin
          stallPrev = 1;
          prevCoeff = out_coeff;
          prevAddr  = out_addr;
          prevPoly  = out_poly;
        end
      end
      @(posedge clk); #1;
    end

    start     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    if (!doneSeen) begin
      checks++;
      failures++;
      $display("[TB] FAIL job_timeout got=%0d transfers exp=%0d", got, total);
    end else begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
        failures++;
        $display("[TB] FAIL after_done done=%b busy=%b in_ready=%b exp all 0", done, busy, in_ready);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 ||
        out_coeff !== 32'd0 || out_addr !== 8'd0 || out_poly !== 3'd0) begin
      failures++;
      $display("[TB] FAIL %s got ir=%b ov=%b b=%b d=%b e=%b c=%0d a=%0d p=%0d exp all 0",
               tag, in_ready, out_valid, busy, done, err, out_coeff, out_addr, out_poly);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; num_polys = '0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_single_word();
    run_job(4'd1, 1'b1, 32'h01234567, 100, 100, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_two_polys();
    run_job(4'd2, 1'b0, 32'h0, 100, 100, 1'b0, 1'b0, -1, 1'b1);
  endtask

  task automatic test_stall();
    run_job(4'd1, 1'b0, 32'h0, 100, 0, 1'b1, 1'b0, -1, 1'b0);
  endtask

  task automatic test_range();
    run_job(4'd1, 1'b1, 32'h8888888F, 90, 90, 1'b0, 1'b0, -1, 1'b0);
    run_job(4'd1, 1'b1, 32'h01234567, 90, 90, 1'b0, 1'b0, -1, 1'b0);
  endtask

  task automatic test_saturation();
    run_job(4'd12, 1'b0, 32'h0, 85, 85, 1'b0, 1'b1, -1, 1'b0);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 3; j++) begin
      run_job(4'($urandom_range(3, 1)), 1'b0, 32'h0, int'($urandom_range(100, 30)),
              int'($urandom_range(100, 30)), 1'b0, 1'b1, -1, 1'b0);
    end
  endtask

  task automatic test_reset_midjob();
    run_job(4'd2, 1'b0, 32'h0, 100, 100, 1'b0, 1'b0, 256 + 20, 1'b0);
    rst_n = 1'b0;
    #2;
    check_all_zero("midjob_reset");
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("[TB] FAIL no_done_after_reset cycle=%0d done=%b busy=%b exp 0 0", i, done, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_zero_polys();
    run_job(4'd0, 1'b0, 32'h0, 100, 100, 1'b0, 1'b0, -1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_two_polys();
    test_stall();
    test_range();
    test_saturation();
    test_random_jobs();
    test_reset_midjob();
    test_zero_polys();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
